// File: rtl/root_seq_ctrl.sv
// Sequenced float16 nth-root: log2 via external PWL, restoring divide by n, pow2 via external PWL.
// Special operands and illegal orders bypass straight to the result state.
module root_seq_ctrl #(
  parameter logic [15:0] NAN_CODE = 16'h7E00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] x_in,
  input  logic [2:0]  n_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] y_out,
  output logic        err,
  output logic [13:0] log_x_o,
  input  logic [15:0] log_y_i,
  output logic [15:0] pow_x_o,
  input  logic [15:0] pow_y_i
);

  typedef enum logic [2:0] {StIdle, StLog, StDiv, StPow, StPack, StDone} state_e;

  state_e      state_q;
  logic [14:0] x_q;
  logic [2:0]  n_q;
  logic [15:0] dvd_q;
  logic [2:0]  rem_q;
  logic        neg_q;
  logic [4:0]  cnt_q;
  logic [3:0]  pi_q;
  logic [15:0] pow_y_q;
  logic [15:0] y_q;
  logic        err_q;
  logic        out_valid_q;

  logic        spec_hit, spec_err;
  logic [15:0] spec_y;
  logic [15:0] e_off, log_x, log_mag, q;
  logic [3:0]  rem_sh;
  logic        q_bit;
  logic [2:0]  rem_nx;
  logic signed [5:0] exp_o;
  logic [9:0]  mant;
  logic [15:0] pack_y;

  // Special-case decode on the raw request; the order check wins over everything.
  always_comb begin
    spec_hit = 1'b1;
    spec_err = 1'b0;
    spec_y   = NAN_CODE;
    if (n_in < 3'd2) begin
      spec_err = 1'b1;
    end else if (x_in[14:10] == 5'd0) begin
      spec_y = 16'h0000;
    end else if (x_in[14:10] == 5'd31 && x_in[9:0] != 10'd0) begin
      spec_y = NAN_CODE;
    end else if (x_in[15]) begin
      spec_err = 1'b1;
    end else if (x_in[14:10] == 5'd31) begin
      spec_y = 16'h7C00;
    end else begin
      spec_hit = 1'b0;
    end
  end

  always_comb begin
    log_x_o = (state_q == StLog) ? {2'b01, x_q[9:0], 2'b00} : 14'd0;
    e_off   = {11'b0, x_q[14:10]} - 16'd15;
    log_x   = log_y_i + {e_off[3:0], 12'b0};
    log_mag = log_x[15] ? (~log_x + 16'd1) : log_x;

    rem_sh = {rem_q, dvd_q[15]};
    q_bit  = rem_sh >= {1'b0, n_q};
    rem_nx = q_bit ? (rem_sh[2:0] - n_q) : rem_sh[2:0];

    // Floor division: a negative dividend with nonzero remainder rounds one further down.
    if (!neg_q)               q = dvd_q;
    else if (rem_q != 3'd0)   q = ~dvd_q;
    else                      q = ~dvd_q + 16'd1;
    pow_x_o = (state_q == StPow) ? {4'b0, q[11:0]} : 16'd0;

    exp_o = $signed({{2{pi_q[3]}}, pi_q}) + 6'sd15;
    if (pow_y_q < 16'd4096)       mant = 10'd0;
    else if (pow_y_q >= 16'd8192) mant = 10'h3FF;
    else                          mant = pow_y_q[11:2];
    if (exp_o < 6'sd1)       pack_y = 16'h0000;
    else if (exp_o > 6'sd30) pack_y = 16'h7C00;
    else                     pack_y = {1'b0, exp_o[4:0], mant};
  end

  assign in_ready  = (state_q == StIdle) && !rst;
  assign out_valid = out_valid_q;
  assign y_out     = y_q;
  assign err       = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      x_q         <= '0;
      n_q         <= '0;
      dvd_q       <= '0;
      rem_q       <= '0;
      neg_q       <= 1'b0;
      cnt_q       <= '0;
      pi_q        <= '0;
      pow_y_q     <= '0;
      y_q         <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            x_q <= x_in[14:0];
            n_q <= n_in;
            if (spec_hit) begin
              y_q         <= spec_y;
              err_q       <= spec_err;
              out_valid_q <= 1'b1;
              state_q     <= StDone;
            end else begin
              state_q <= StLog;
            end
          end
        end
        StLog: begin
          dvd_q   <= log_mag;
          neg_q   <= log_x[15];
          rem_q   <= '0;
          cnt_q   <= '0;
          state_q <= StDiv;
        end
        StDiv: begin
          dvd_q <= {dvd_q[14:0], q_bit};
          rem_q <= rem_nx;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd15) state_q <= StPow;
        end
        StPow: begin
          pow_y_q <= pow_y_i;
          pi_q    <= q[15:12];
          state_q <= StPack;
        end
        StPack: begin
          y_q         <= pack_y;
          err_q       <= 1'b0;
          out_valid_q <= 1'b1;
          state_q     <= StDone;
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_root_seq_ctrl.sv
// Scoreboard bench for root_seq_ctrl: accepted requests push model results, a monitor pops on
// each new out_valid and checks value, error flag and latency.
module tb_root_seq_ctrl;

  localparam logic [15:0] NAN = 16'h7E00;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, err;
  logic [15:0] x_in, y_out, log_y_i, pow_x_o, pow_y_i;
  logic [2:0]  n_in;
  logic [13:0] log_x_o;

  root_seq_ctrl #(.NAN_CODE(NAN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in), .n_in(n_in),
    .out_valid(out_valid), .out_ready(out_ready), .y_out(y_out), .err(err),
    .log_x_o(log_x_o), .log_y_i(log_y_i), .pow_x_o(pow_x_o), .pow_y_i(pow_y_i)
  );

  always #5 clk = ~clk;

  // External PWL stand-ins: slightly bowed log2(1+f) and a pow2 that can overshoot 2.0.
  function automatic logic [15:0] log_pwl(input int lxo);
    int d;
    if (lxo < 4096) return 16'd0;
    d = lxo - 4096;
    return 16'(d + (d * (4096 - d)) / 16384);
  endfunction

  function automatic logic [15:0] pow_pwl(input int p);
    return 16'(4096 + p + (p >> 3));
  endfunction

  always_comb log_y_i = log_pwl(int'(log_x_o));
  always_comb pow_y_i = pow_pwl(int'(pow_x_o));

  // Reference: {err, y} from the nth-root rules with plain integer arithmetic.
  function automatic logic [16:0] model(input logic [15:0] x, input logic [2:0] n);
    int e, f, lx, q, pi, fr, py, eo, m;
    logic [15:0] y;
    e = int'(x[14:10]);
    f = int'(x[9:0]);
    if (n < 3'd2) return {1'b1, NAN};
    if (e == 0) return {1'b0, 16'h0000};
    if (e == 31 && f != 0) return {1'b0, NAN};
    if (x[15]) return {1'b1, NAN};
    if (e == 31) return {1'b0, 16'h7C00};
    lx = int'(log_pwl(4096 + 4 * f)) + (e - 15) * 4096;
    q = lx / int'(n);
    if (lx < 0 && q * int'(n) != lx) q = q - 1;
    pi = (q >= 0) ? q / 4096 : -((-q + 4095) / 4096);
    fr = q - pi * 4096;
    py = int'(pow_pwl(fr));
    eo = pi + 15;
    if (eo < 1) y = 16'h0000;
    else if (eo > 30) y = 16'h7C00;
    else begin
      if (py < 4096) m = 0;
      else if (py >= 8192) m = 1023;
      else m = (py - 4096) / 4;
      y = {1'b0, eo[4:0], m[9:0]};
    end
    return {1'b0, y};
  endfunction

  function automatic bit is_special(input logic [15:0] x, input logic [2:0] n);
    return (n < 3'd2) || (x[14:10] == 5'd0) || (x[14:10] == 5'd31) || x[15];
  endfunction

  typedef struct {
    logic [15:0] y;
    logic        err;
    int          lat;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_out = 0;
  bit   ov_prev = 1'b0;

  function automatic void chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Accept side of the scoreboard.
  always @(posedge clk) begin
    exp_t e;
    logic [16:0] r;
    if (rst) sb.delete();
    else if (in_valid && in_ready) begin
      r     = model(x_in, n_in);
      e.y   = r[15:0];
      e.err = r[16];
      e.lat = is_special(x_in, n_in) ? 1 : 20;
      e.cyc = cyc;
      sb.push_back(e);
    end
  end

  // Result side: one pop per out_valid rise.
  always @(negedge clk) begin
    exp_t e;
    if (rst) ov_prev = 1'b0;
    else begin
      if (out_valid && !ov_prev) begin
        n_out++;
        if (sb.size() == 0) chk("unexpected_out", 1, 0);
        else begin
          e = sb.pop_front();
          chk("y_out", int'(y_out), int'(e.y));
          chk("err", int'(err), int'(e.err));
          chk("latency", cyc - e.cyc, e.lat);
        end
      end
      ov_prev = out_valid;
    end
  end

  task automatic issue(input logic [15:0] x, input logic [2:0] n, output int acc_cyc);
    bit ok;
    ok = 1'b0;
    acc_cyc = -1;
    @(negedge clk);
    in_valid = 1'b1;
    x_in = x;
    n_in = n;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(posedge clk);
      if (in_ready) begin
        ok = 1'b1;
        acc_cyc = cyc;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && (sb.size() != 0 || out_valid); i++) @(negedge clk);
    chk("sb_drain", sb.size(), 0);
  endtask

  initial begin
    int          ac, prev_ac;
    logic [16:0] r;
    logic [15:0] xs[8];
    logic [2:0]  ns[8];
    bit          seen;

    rst = 1'b1;
    in_valid = 1'b0;
    x_in = '0;
    n_in = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_y_out", int'(y_out), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_log_x_o", int'(log_x_o), 0);
    chk("rst_pow_x_o", int'(pow_x_o), 0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", int'(in_ready), 1);

    // Directed values incl. all bypass classes.
    xs = '{16'h4400, 16'h3400, 16'hC400, 16'h0000, 16'h4400, 16'h7C00, 16'h7E01, 16'hFC00};
    ns = '{3'd2, 3'd2, 3'd3, 3'd3, 3'd1, 3'd2, 3'd2, 3'd2};
    for (int i = 0; i < 8; i++) issue(xs[i], ns[i], ac);
    drain();
    chk("y_4_sqrt", int'(model(16'h4400, 3'd2)), 17'h04000);
    chk("y_quarter_sqrt", int'(model(16'h3400, 3'd2)), 17'h03800);

    // Hold in DONE with consumer stalled.
    out_ready = 1'b0;
    issue(16'h4400, 3'd3, ac);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = out_valid;
    end
    if (!seen) chk("hold_timeout", 0, 1);
    r = model(16'h4400, 3'd3);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      x_in = 16'h4800 + 16'(i);
      n_in = 3'd2;
      @(negedge clk);
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_y", int'(y_out), int'(r[15:0]));
      chk("hold_err", int'(err), int'(r[16]));
      chk("hold_in_ready", int'(in_ready), 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_valid", int'(out_valid), 0);
    chk("release_in_ready", int'(in_ready), 1);

    // Reset in the middle of the divide.
    issue(16'h4400, 3'd2, ac);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 0);
    chk("midrst_y_out", int'(y_out), 0);
    @(negedge clk);
    rst = 1'b0;
    issue(16'h4400, 3'd2, ac);
    drain();

    // Streamed legal transactions with in_valid held high.
    prev_ac = -1;
    @(negedge clk);
    in_valid = 1'b1;
    x_in = {1'b0, 5'($urandom_range(9, 22)), 10'($urandom)};
    n_in = 3'($urandom_range(2, 7));
    for (int t = 0; t < 7; t++) begin
      seen = 1'b0;
      ac = -1;
      for (int i = 0; i < 60 && !seen; i++) begin
        @(posedge clk);
        if (in_ready) begin
          seen = 1'b1;
          ac = cyc;
        end
      end
      if (!seen) chk("stream_timeout", 0, 1);
      if (prev_ac >= 0) chk("stream_spacing", ac - prev_ac, 21);
      prev_ac = ac;
      @(negedge clk);
      x_in = {1'b0, 5'($urandom_range(9, 22)), 10'($urandom)};
      n_in = 3'($urandom_range(2, 7));
      if (t == 6) in_valid = 1'b0;
    end
    drain();

    // Random mix of normal and bypass requests.
    for (int t = 0; t < 12; t++) begin
      logic [15:0] x;
      logic [2:0]  n;
      x = {1'b0, 5'($urandom_range(9, 22)), 10'($urandom)};
      n = 3'($urandom_range(2, 7));
      case ($urandom_range(0, 5))
        0: n = 3'($urandom_range(0, 1));
        1: x[14:10] = 5'd0;
        2: x[14:10] = 5'd31;
        3: x[15] = 1'b1;
        default: ;
      endcase
      issue(x, n, ac);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
